// File: rtl/lsu_pkg.sv
// Shared types and access-size encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores (byte enables, data replication, legality)
// and lane extraction with sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic       bad_f3, bad_st, bad_h, bad_w;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << req_off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {req_off[1], 1'b0};
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Unsigned sizes exist only for loads; reserved encodings are always illegal.
    assign bad_f3   = req_funct3 inside {3'b011, 3'b110, 3'b111};
    assign bad_st   = req_we & (req_funct3 inside {F3_BU, F3_HU});
    assign bad_h    = (req_funct3 inside {F3_H, F3_HU}) & req_off[0];
    assign bad_w    = (req_funct3 == F3_W) & (req_off != 2'b00);
    assign misalign = req_valid & (bad_f3 | bad_st | bad_h | bad_w);

    assign ld_byte = 8'(ld_word >> {ld_off, 3'b000});
    assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_data = 32'h0;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bridging the core data port to a handshaked, variable-latency
// memory bus; stalls the core from request until the response cycle.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             we_q;
    logic [31:0]      data_q;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      ld_data;

    lsu_align u_align (
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .misalign   (misalign),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .ld_word    (data_q),
        .ld_data    (ld_data)
    );

    // The IDLE request cycle stalls combinationally so the core holds PC right away.
    assign stall = ~reset & ((state == BUSY) | ((state == IDLE) & req_valid & ~misalign));
    assign rdata = ((state == RESP) && !we_q) ? ld_data : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            we_q      <= 1'b0;
            data_q    <= 32'h0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !misalign) begin
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        we_q      <= req_we;
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_be    <= be;
                        bus_wdata <= wdata_rep;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!we_q) data_q <= bus_rdata;
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        bus_req <= 1'b0;
                        data_q  <= 32'h0;
                        fault   <= 1'b1;
                        cnt     <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: expected responses are queued when a request
// is driven and compared when the unit reaches its response cycle.
module tb_lsu_bus_ctrl;
    import lsu_pkg::*;

    localparam int TIMEOUT_CYC = 15;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .misalign   (misalign),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access; ack_cyc = BUSY cycle carrying the ack, 0 = never ack.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] rword,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_fault, input string tag);
        int    busy;
        int    n_stall;
        int    exp_busy;
        logic  done;
        resp_t e;
        exp_busy = (ack_cyc == 0) ? TIMEOUT_CYC : ack_cyc;
        exp_q.push_back('{rdata: exp_rd, fault: exp_fault});
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check({tag, " idle stall"}, 32'(stall), 32'd1);
        busy    = 0;
        n_stall = 1;
        done    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) begin
                done = 1'b1;
                break;
            end
            busy++;
            n_stall++;
            check({tag, " bus_req busy"}, 32'(bus_req), 32'd1);
            if (busy == 1) begin
                check({tag, " bus_addr"}, bus_addr, addr & ~32'h3);
                check({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
                check({tag, " bus_wdata"}, bus_wdata, exp_wd);
                check({tag, " bus_we"}, 32'(bus_we), 32'(we));
            end
            if (busy == ack_cyc) begin
                bus_ack   = 1'b1;
                bus_rdata = rword;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
        end
        bus_ack = 1'b0;
        check({tag, " reached resp"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, 32'(n_stall), 32'(1 + exp_busy));
        e = exp_q.pop_front();
        check({tag, " rdata"}, rdata, e.rdata);
        check({tag, " fault"}, 32'(fault), 32'(e.fault));
        check({tag, " bus_req resp"}, 32'(bus_req), 32'd0);
        @(negedge clk);
        check({tag, " no reissue"}, 32'(bus_req), 32'd0);
        req_valid = 1'b0;
    endtask

    task automatic misaligned(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input string tag);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = 32'h1111_2222;
        #1;
        check({tag, " misalign"}, 32'(misalign), 32'd1);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " rdata"}, rdata, 32'h0);
        @(negedge clk);
        check({tag, " bus_req"}, 32'(bus_req), 32'd0);
        check({tag, " stays idle"}, 32'(stall), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h100;
        req_wdata  = 32'h55;
        bus_ack    = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset bus_be", 32'(bus_be), 32'd0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset fault", 32'(fault), 32'd0);
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        reset     = 1'b0;

        access(1'b1, F3_W,  32'd100,  32'd25,       1, 32'h0,        4'b1111, 32'd25,       32'h0,        1'b0, "sw");
        access(1'b0, F3_B,  32'h61,   32'h0,        3, 32'h1234_80FF, 4'b0010, 32'h0,        32'hFFFF_FF80, 1'b0, "lb");
        access(1'b0, F3_BU, 32'h61,   32'h0,        3, 32'h1234_80FF, 4'b0010, 32'h0,        32'h0000_0080, 1'b0, "lbu");
        access(1'b1, F3_H,  32'h62,   32'hAAAA_BEEF, 2, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, "sh");
        access(1'b0, F3_HU, 32'h62,   32'h0,        1, 32'hBEEF_0000, 4'b1100, 32'h0,        32'h0000_BEEF, 1'b0, "lhu");
        access(1'b0, F3_H,  32'h60,   32'h0,        2, 32'h0000_8001, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0, "lh");
        access(1'b1, F3_B,  32'h43,   32'h1234_565A, 1, 32'h0,        4'b1000, 32'h5A5A_5A5A, 32'h0,        1'b0, "sb");
        access(1'b0, F3_B,  32'h43,   32'h0,        1, 32'h7F00_0000, 4'b1000, 32'h0,        32'h0000_007F, 1'b0, "lb3");

        misaligned(1'b0, F3_W,   32'h66, "lw66");
        misaligned(1'b1, F3_H,   32'h63, "sh63");
        misaligned(1'b0, 3'b011, 32'h40, "f3_011");
        misaligned(1'b1, F3_BU,  32'h40, "sbu");

        access(1'b0, F3_W, 32'h200, 32'h0, 0, 32'h0,        4'b1111, 32'h0, 32'h0,        1'b1, "lw timeout");
        access(1'b0, F3_W, 32'h204, 32'h0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, "lw after timeout");

        // Reset lands in the second BUSY cycle; a late ack must be ignored.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h300;
        req_wdata  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid reset pre bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset bus_req", 32'(bus_req), 32'd0);
        check("mid reset stall", 32'(stall), 32'd0);
        check("mid reset rdata", rdata, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ack = 1'b0;
        check("late ack bus_req", 32'(bus_req), 32'd0);
        check("late ack stall", 32'(stall), 32'd0);
        check("late ack fault", 32'(fault), 32'd0);
        check("late ack rdata", rdata, 32'h0);

        access(1'b1, F3_W, 32'h304, 32'hA5A5_0001, 1, 32'h0, 4'b1111, 32'hA5A5_0001, 32'h0, 1'b0, "sw after reset");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
